// File: rtl/fpu_mult_sequencer_if.sv
// Byte-stream and multiplier-core signals of the FP multiply sequencer.
// slave = sequencer side, master = pins/core side.
interface fpu_mult_sequencer_if #(
   parameter int OP_W = 32
);
   logic [7:0]      in_data;
   logic            in_valid;
   logic            in_ready;
   logic [OP_W-1:0] mul_a;
   logic [OP_W-1:0] mul_b;
   logic            mul_start;
   logic            mul_done;
   logic [OP_W-1:0] mul_result;
   logic [7:0]      out_data;
   logic            out_valid;
   logic            out_ready;
   logic            busy;
   logic            timeout_err;

   modport slave (
      input  in_data, in_valid, mul_done, mul_result, out_ready,
      output in_ready, mul_a, mul_b, mul_start, out_data, out_valid, busy, timeout_err
   );

   modport master (
      output in_data, in_valid, mul_done, mul_result, out_ready,
      input  in_ready, mul_a, mul_b, mul_start, out_data, out_valid, busy, timeout_err
   );
endinterface

// File: rtl/fpu_mult_sequencer.sv
// Byte-serial operand collector / result streamer around the FP multiplier core.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_LOAD   | accept 2*NB operand bytes, A then B, LSB first
// S_ISSUE  | one-cycle mul_start pulse, clear timeout flag and wait counter
// S_WAIT   | wait for mul_done or TIMEOUT cycles, capture result (or NaN)
// S_UNLOAD | stream NB result bytes, LSB first
module fpu_mult_sequencer #(
   parameter int              OP_W    = 32,
   parameter int              TIMEOUT = 64,
   parameter logic [OP_W-1:0] NAN_VAL = 32'h7FC0_0000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fpu_mult_sequencer_if.slave  bus
);

   localparam int NB = OP_W / 8;
   localparam int CW = $clog2(2 * NB);
   localparam int OW = (NB > 1) ? $clog2(NB) : 1;
   localparam int TW = $clog2(TIMEOUT);

   localparam logic [CW-1:0] LAST_IN   = CW'(2 * NB - 1);
   localparam logic [OW-1:0] LAST_OUT  = OW'(NB - 1);
   localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_LOAD   = 2'd0,
      S_ISSUE  = 2'd1,
      S_WAIT   = 2'd2,
      S_UNLOAD = 2'd3
   } state_e;

   state_e          state_q,  state_d;
   logic [CW-1:0]   cnt_q,    cnt_d;
   logic [OW-1:0]   obyte_q,  obyte_d;
   logic [TW-1:0]   wait_q,   wait_d;
   logic [OP_W-1:0] mul_a_q,  mul_a_d;
   logic [OP_W-1:0] mul_b_q,  mul_b_d;
   logic [OP_W-1:0] result_q, result_d;
   logic            terr_q,   terr_d;

   logic in_xfer;
   logic out_xfer;

   assign in_xfer  = (state_q == S_LOAD)   && bus.in_valid;
   assign out_xfer = (state_q == S_UNLOAD) && bus.out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_LOAD;
         cnt_q    <= '0;
         obyte_q  <= '0;
         wait_q   <= '0;
         mul_a_q  <= '0;
         mul_b_q  <= '0;
         result_q <= '0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         obyte_q  <= obyte_d;
         wait_q   <= wait_d;
         mul_a_q  <= mul_a_d;
         mul_b_q  <= mul_b_d;
         result_q <= result_d;
         terr_q   <= terr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      obyte_d  = obyte_q;
      wait_d   = wait_q;
      mul_a_d  = mul_a_q;
      mul_b_d  = mul_b_q;
      result_d = result_q;
      terr_d   = terr_q;

      unique case (state_q)
         S_LOAD: begin
            if (in_xfer) begin
               for (int i = 0; i < NB; i++) begin
                  if (cnt_q == CW'(i))      mul_a_d[8*i +: 8] = bus.in_data;
                  if (cnt_q == CW'(NB + i)) mul_b_d[8*i +: 8] = bus.in_data;
               end
               if (cnt_q == LAST_IN) begin
                  cnt_d   = '0;
                  state_d = S_ISSUE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_ISSUE: begin
            terr_d  = 1'b0;
            wait_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            wait_d = wait_q + 1'b1;
            // A real result beats the timeout when both land in the same cycle.
            if (bus.mul_done) begin
               result_d = bus.mul_result;
               state_d  = S_UNLOAD;
            end else if (wait_q == WAIT_LAST) begin
               result_d = NAN_VAL;
               terr_d   = 1'b1;
               state_d  = S_UNLOAD;
            end
         end
         S_UNLOAD: begin
            if (out_xfer) begin
               if (obyte_q == LAST_OUT) begin
                  obyte_d = '0;
                  state_d = S_LOAD;
               end else begin
                  obyte_d = obyte_q + 1'b1;
               end
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_comb begin
      bus.in_ready    = (state_q == S_LOAD);
      bus.mul_start   = (state_q == S_ISSUE);
      bus.out_valid   = (state_q == S_UNLOAD);
      bus.busy        = !((state_q == S_LOAD) && (cnt_q == '0));
      bus.timeout_err = terr_q;
      bus.mul_a       = mul_a_q;
      bus.mul_b       = mul_b_q;
      bus.out_data    = '0;
      for (int i = 0; i < NB; i++) begin
         if (obyte_q == OW'(i)) bus.out_data = result_q[8*i +: 8];
      end
   end

endmodule

// File: tb/tb_fpu_mult_sequencer.sv
// Bench for fpu_mult_sequencer: vector table of operations with a result-byte
// scoreboard, plus a hand-written mid-load reset sequence.
module tb_fpu_mult_sequencer;

   localparam int          TO  = 64;
   localparam logic [31:0] NAN = 32'h7FC0_0000;

   logic clk;
   logic rst_n;

   fpu_mult_sequencer_if #(.OP_W(32)) bus ();

   fpu_mult_sequencer #(.OP_W(32), .TIMEOUT(TO), .NAN_VAL(NAN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int start_cnt = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      int          done_at;    // WAIT-cycle index of mul_done, -1 = never
      logic [31:0] res;
      int          stall_j;    // result byte before which out_ready drops, -1 = none
      int          stall_len;
      int          gap;        // idle cycles before each input byte
      bit          stray;      // pulse mul_done in gaps and in ISSUE
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (bus.mul_start) start_cnt++;
   end

   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            chk("out_byte_unexpected", {24'd0, bus.out_data}, 32'hXXXX_XXXX);
         end else begin
            chk("out_byte", {24'd0, bus.out_data}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap, input bit stray);
      for (int g = 0; g < gap; g++) begin
         bus.in_valid   = 1'b0;
         bus.mul_done   = stray;
         bus.mul_result = 32'hDEAD_BEEF;
         tick();
      end
      bus.mul_done = 1'b0;
      chk("in_ready_load", {31'd0, bus.in_ready}, 32'd1);
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic run_op(input vec_t v);
      logic [31:0] er;
      logic [31:0] tmp;
      logic        et;
      logic [7:0]  held;
      int          s0;
      et = !(v.done_at >= 0 && v.done_at < TO);
      er = et ? NAN : v.res;
      for (int i = 0; i < 4; i++) exp_q.push_back(er[8*i +: 8]);

      for (int k = 0; k < 8; k++) begin
         tmp = (k < 4) ? v.a : v.b;
         send_byte(tmp[8*(k%4) +: 8], v.gap, v.stray);
         if (k < 7) chk("busy_load", {31'd0, bus.busy}, 32'd1);
      end

      // ISSUE cycle
      chk("mul_start", {31'd0, bus.mul_start}, 32'd1);
      chk("mul_a", bus.mul_a, v.a);
      chk("mul_b", bus.mul_b, v.b);
      chk("in_ready_issue", {31'd0, bus.in_ready}, 32'd0);
      s0 = start_cnt;
      bus.mul_done   = v.stray;
      bus.mul_result = 32'hDEAD_BEEF;
      tick();
      bus.mul_done = 1'b0;
      chk("start_one_cycle", {31'd0, bus.mul_start}, 32'd0);
      chk("terr_cleared", {31'd0, bus.timeout_err}, 32'd0);

      for (int w = 0; w < TO; w++) begin
         chk("wait_no_out", {30'd0, bus.out_valid, bus.in_ready}, 32'd0);
         if (w == v.done_at) begin
            bus.mul_done   = 1'b1;
            bus.mul_result = v.res;
         end
         tick();
         bus.mul_done   = 1'b0;
         bus.mul_result = 32'hDEAD_BEEF;
         if (w == v.done_at) break;
      end

      chk("out_valid_unload", {31'd0, bus.out_valid}, 32'd1);
      chk("timeout_err", {31'd0, bus.timeout_err}, {31'd0, et});
      chk("start_pulses", start_cnt - s0, 32'd1);

      for (int j = 0; j < 4; j++) begin
         if (j == v.stall_j) begin
            bus.out_ready = 1'b0;
            held = bus.out_data;
            for (int s = 0; s < v.stall_len; s++) begin
               tick();
               chk("stall_hold", {24'd0, bus.out_data}, {24'd0, held});
               chk("stall_flags", {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
            end
         end
         bus.out_ready = 1'b1;
         tick();
         bus.out_ready = 1'b0;
      end

      chk("back_to_load", {29'd0, bus.out_valid, bus.in_ready, bus.busy}, 32'd2);
      chk("mul_a_stable", bus.mul_a, v.a);
      chk("mul_b_stable", bus.mul_b, v.b);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      chk({tag, "_flags"}, {28'd0, bus.mul_start, bus.out_valid, bus.busy, bus.timeout_err}, 32'd0);
      chk({tag, "_mul_a"}, bus.mul_a, 32'd0);
      chk({tag, "_mul_b"}, bus.mul_b, 32'd0);
      chk({tag, "_out_data"}, {24'd0, bus.out_data}, 32'd0);
   endtask

   vec_t tbl[7];

   initial begin
      tbl[0] = '{32'h4000_0000, 32'h4040_0000, 2,      32'h40C0_0000, -1, 0, 0, 1'b0};
      tbl[1] = '{32'h4000_0000, 32'h4040_0000, -1,     32'h1234_5678, -1, 0, 0, 1'b0};
      tbl[2] = '{32'h3F80_0000, 32'h3F80_0000, 0,      32'h3F80_0000,  2, 5, 0, 1'b0};
      tbl[3] = '{32'hC120_0000, 32'h40A0_0000, 10,     32'hC248_0000, -1, 0, 2, 1'b1};
      tbl[4] = '{32'h1122_3344, 32'h5566_7788, TO - 1, 32'h44AA_BBCC,  0, 3, 0, 1'b0};
      tbl[5] = '{32'hA5A5_0F0F, 32'h0102_0304, TO - 2, 32'hCAFE_F00D,  3, 1, 1, 1'b1};
      tbl[6] = '{32'h8765_4321, 32'hFEDC_BA98, 5,      32'h0BAD_CAFE, -1, 0, 0, 1'b0};

      rst_n          = 1'b0;
      bus.in_data    = '0;
      bus.in_valid   = 1'b0;
      bus.mul_done   = 1'b0;
      bus.mul_result = '0;
      bus.out_ready  = 1'b0;
      tick();
      tick();
      chk_reset_vals("por");
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) run_op(tbl[i]);

      // Timeout op leaves timeout_err set, then reset lands after 5 load bytes.
      run_op(tbl[1]);
      chk("terr_sticky", {31'd0, bus.timeout_err}, 32'd1);
      for (int k = 0; k < 5; k++) send_byte(8'h5A + 8'(k), 0, 1'b0);
      chk("busy_partial", {31'd0, bus.busy}, 32'd1);
      rst_n = 1'b0;
      tick();
      chk_reset_vals("midload_rst");
      rst_n = 1'b1;
      run_op(tbl[6]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
